muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer for the execute stage. It accepts MULT/MULTU/DIV/DIVU commands alongside the single-cycle ALU and computes one radix-2 step per cycle. It holds the stall request to the hazard unit while running and owns the architectural HI/LO registers (MTHI/MTLO writes, MFHI/MFLO reads).

## Interface
Parameters:
- PC_BITS, 32, operand/result width; the iteration count equals PC_BITS

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- start_e  in  1  command valid in execute
- op_e  in  2  command: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src_a_e  in  PC_BITS  multiplicand / dividend
- src_b_e  in  PC_BITS  multiplier / divisor
- flush_e  in  1  abort any in-flight operation
- mthi_e  in  1  write HI from src_a_e
- mtlo_e  in  1  write LO from src_a_e
- busy_e  out  1  stall request; high whenever state != IDLE
- done_e  out  1  one-cycle pulse; HI/LO hold the new result
- div_zero_e  out  1  valid with done_e; the completed op was a divide by zero
- hi_out  out  PC_BITS  HI register
- lo_out  out  PC_BITS  LO register

## Operation
- State machine: IDLE, RUN, FIX.
- IDLE with start_e=1 and flush_e=0:
  - latch op, |src_a_e|, |src_b_e|, and sign bits (signed ops only; unsigned ops take raw values);
  - count<=0; go to RUN.
- RUN, one step per edge; count increments; go to FIX on the edge where count==PC_BITS-1.
  - Multiply: shift-add into a 2*PC_BITS accumulator, LSB-first.
  - Divide: restoring shift-subtract.
- FIX, one edge: apply sign correction, write HI/LO, pulse done_e for the following cycle, go to IDLE.
- Sign rules:
  - product sign = sa^sb;
  - quotient sign = sa^sb;
  - remainder sign = sa.
- Results:
  - MULT/MULTU: HI = upper half, LO = lower half;
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: runs full latency. Result is LO=all ones, HI=original src_a_e, and div_zero_e=1 with done_e.
- Signed overflow (most-negative / -1): LO=0x80000000, HI=0, no flag.
- mthi_e/mtlo_e:
  - honoured only in IDLE with start_e=0; written on that edge;
  - ignored while busy (the hazard unit must stall them).
- Priority:
  - flush_e > start_e > mthi_e/mtlo_e;
  - start_e while busy is ignored.
- flush_e in RUN/FIX: go to IDLE on the next edge, with no done_e and HI/LO unchanged.

## Timing
- Reset values: state=IDLE, busy_e=0, done_e=0, div_zero_e=0, hi_out=0, lo_out=0, count=0.
- Latency, with start sampled at edge E0:
  - RUN spans E1..E(PC_BITS);
  - FIX at E(PC_BITS+1) writes HI/LO;
  - done_e is high for the single cycle after that edge.
  - At PC_BITS=32: 33 edges from start to HI/LO valid.
- busy_e is registered: high from the cycle after E0 through the cycle before done_e. Total 33 cycles at PC_BITS=32.
- A new start_e may be accepted in the same cycle done_e is high (state is IDLE).
- hi_out/lo_out change only on FIX, mthi/mtlo or reset. They are stable during RUN, so a stalled MFHI sees the old value.
- Reset asserted mid-operation: immediate return to reset values, with no done_e after release.

## Test plan
- MULT 0xFFFFFFFF x 0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE; busy_e high exactly 33 cycles; done_e one pulse.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero_e=1 with done_e.
- Start MULTU 3 x 5, assert flush_e at RUN count 10 -> next cycle busy_e=0, no done_e, HI/LO keep their prior values; a second start_e pulsed during RUN is ignored.
- mtlo_e with src_a_e=0xCAFEF00D in IDLE -> LO=0xCAFEF00D; mthi_e during RUN -> HI unchanged; start_e+mthi_e in the same idle cycle -> operation starts, HI not written.
- Deassert rst_n at RUN count 20 -> all outputs return to reset values immediately; after release, no done_e and busy_e=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide sequencer with HI/LO registers
// Operands are reduced to magnitudes on entry; signs are restored in the FIX cycle.
module muldiv_unit #(
  parameter int PC_BITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_e,
  input  logic [1:0]         op_e,
  input  logic [PC_BITS-1:0] src_a_e,
  input  logic [PC_BITS-1:0] src_b_e,
  input  logic               flush_e,
  input  logic               mthi_e,
  input  logic               mtlo_e,
  output logic               busy_e,
  output logic               done_e,
  output logic               div_zero_e,
  output logic [PC_BITS-1:0] hi_out,
  output logic [PC_BITS-1:0] lo_out
);

  localparam int N  = PC_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count;
  logic            r_is_div, r_sa, r_sb;
  logic [N-1:0]    r_opnd;
  logic [2*N-1:0]  r_acc;
  logic [N-1:0]    r_hi, r_lo;
  logic            r_done, r_div_zero;

  logic            w_accept, w_finish, w_step;
  logic            w_signed, w_a_neg, w_b_neg;
  logic [N-1:0]    w_a_abs, w_b_abs;
  logic [N:0]      w_mul_sum, w_div_sh, w_div_diff;
  logic [2*N-1:0]  w_mul_step, w_div_step, w_prod;
  logic [N-1:0]    w_quot, w_rem, w_fix_hi, w_fix_lo;
  logic            w_div_zero;

  assign w_signed = ~op_e[0];
  assign w_a_neg  = w_signed & src_a_e[N-1];
  assign w_b_neg  = w_signed & src_b_e[N-1];
  assign w_a_abs  = w_a_neg ? -src_a_e : src_a_e;
  assign w_b_abs  = w_b_neg ? -src_b_e : src_b_e;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[N-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
  assign w_div_sh   = r_acc[2*N-1:N-1];
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};
  assign w_div_step = w_div_diff[N] ? {w_div_sh[N-1:0], r_acc[N-2:0], 1'b0}
                                    : {w_div_diff[N-1:0], r_acc[N-2:0], 1'b1};

  // A zero divisor yields remainder = |a|, which sign-corrects back to the raw dividend.
  assign w_div_zero = r_is_div && (r_opnd == '0);
  assign w_prod     = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quot     = (r_sa ^ r_sb) ? -r_acc[N-1:0] : r_acc[N-1:0];
  assign w_rem      = r_sa ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
  assign w_fix_lo   = r_is_div ? (w_div_zero ? '1 : w_quot) : w_prod[N-1:0];
  assign w_fix_hi   = r_is_div ? w_rem : w_prod[2*N-1:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_e && start_e) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (flush_e) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == LAST) w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_finish    = !flush_e;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= w_finish;
      r_div_zero <= w_finish & w_div_zero;
      if (w_accept) begin
        r_is_div <= op_e[1];
        r_sa     <= w_a_neg;
        r_sb     <= w_b_neg;
        r_count  <= '0;
        r_opnd   <= op_e[1] ? w_b_abs : w_a_abs;
        r_acc    <= {{N{1'b0}}, (op_e[1] ? w_a_abs : w_b_abs)};
      end else if (w_step) begin
        r_count <= r_count + CW'(1);
        r_acc   <= r_is_div ? w_div_step : w_mul_step;
      end
      if (w_finish) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (r_state == S_IDLE && !flush_e && !start_e) begin
        if (mthi_e) r_hi <= src_a_e;
        if (mtlo_e) r_lo <= src_a_e;
      end
    end
  end

  assign busy_e     = (r_state != S_IDLE);
  assign done_e     = r_done;
  assign div_zero_e = r_div_zero;
  assign hi_out     = r_hi;
  assign lo_out     = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_e = 1'b0;
  logic [1:0]  op_e = 2'b00;
  logic [31:0] src_a_e = '0;
  logic [31:0] src_b_e = '0;
  logic        flush_e = 1'b0;
  logic        mthi_e = 1'b0;
  logic        mtlo_e = 1'b0;
  logic        busy_e, done_e, div_zero_e;
  logic [31:0] hi_out, lo_out;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  exp_t exp_q[$];

  muldiv_unit #(.PC_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_e(start_e), .op_e(op_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .flush_e(flush_e),
    .mthi_e(mthi_e), .mtlo_e(mtlo_e), .busy_e(busy_e), .done_e(done_e),
    .div_zero_e(div_zero_e), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    r.dz = 1'b0;
    r.hi = '0;
    r.lo = '0;
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b};     r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          r.lo = 32'hFFFF_FFFF; r.hi = a; r.dz = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else if (op == 2'b10) begin
          r.lo = sa / sb; r.hi = sa % sb;
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_e) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_e=1 expected no result pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_hi", hi_out, e.hi);
        chk("result_lo", lo_out, e.lo);
        chk("div_zero", 32'(div_zero_e), 32'(e.dz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_result);
    if (expect_result) exp_q.push_back(model(op, a, b));
    start_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
    tick();
    start_e = 1'b0;
  endtask

  task automatic wait_done(output int busy_n);
    bit ok;
    busy_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_e) begin ok = 1'b1; break; end
      if (busy_e) busy_n++;
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_e expected one within 100 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bn, d0;
    logic [31:0] ph, pl;

    #1;
    chk("reset_busy", 32'(busy_e), 32'd0);
    chk("reset_done", 32'(done_e), 32'd0);
    chk("reset_dz", 32'(div_zero_e), 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    start_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_done(bn);
    chk("mult_busy_cycles", 32'(bn), 32'd33);
    chk("busy_low_at_done", 32'(busy_e), 32'd0);
    tick();
    chk("done_single_pulse", 32'(done_e), 32'd0);

    start_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_done(bn);
    chk("multu_busy_cycles", 32'(bn), 32'd33);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(bn);
    start_op(2'b11, 32'd100, 32'd7, 1'b1);
    wait_done(bn);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(bn);
    start_op(2'b11, 32'h1234_5678, 32'd0, 1'b1);
    wait_done(bn);
    start_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(bn);
    tick();

    ph = hi_out; pl = lo_out; d0 = done_seen;
    start_op(2'b01, 32'd3, 32'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start_e = 1'b1; op_e = 2'b11; src_a_e = 32'd9; src_b_e = 32'd2;
      end else begin
        start_e = 1'b0;
      end
      tick();
    end
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    chk("flush_busy", 32'(busy_e), 32'd0);
    repeat (40) tick();
    chk("flush_no_done", 32'(done_seen), 32'(d0));
    chk("flush_hi_kept", hi_out, ph);
    chk("flush_lo_kept", lo_out, pl);

    mtlo_e = 1'b1; src_a_e = 32'hCAFE_F00D;
    tick();
    mtlo_e = 1'b0;
    chk("mtlo_idle", lo_out, 32'hCAFE_F00D);

    ph = hi_out;
    start_op(2'b00, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);
    repeat (5) tick();
    mthi_e = 1'b1; src_a_e = 32'h1111_2222;
    tick();
    mthi_e = 1'b0;
    chk("mthi_run_ignored", hi_out, ph);
    wait_done(bn);
    tick();

    ph = hi_out;
    mthi_e = 1'b1;
    start_op(2'b01, 32'hDEAD_0001, 32'd3, 1'b1);
    mthi_e = 1'b0;
    chk("start_mthi_hi", hi_out, ph);
    chk("start_mthi_busy", 32'(busy_e), 32'd1);
    wait_done(bn);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      start_op(op, pick(), pick(), 1'b1);
      wait_done(bn);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    tick();

    d0 = done_seen;
    start_op(2'b10, 32'h7654_3210, 32'd13, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_e), 32'd0);
    chk("rst_done", 32'(done_e), 32'd0);
    chk("rst_dz", 32'(div_zero_e), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rst_no_done", 32'(done_seen), 32'(d0));
    chk("rst_busy_after", 32'(busy_e), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

endmodule
